// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and defaults for the unified memory port arbiter.
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
    localparam int TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/mem_port_arbiter_timer.sv
// mem_port_arbiter_timer: watchdog counting WAIT cycles; expired once the count hits TIMEOUT-1.
module mem_port_arbiter_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT);
    logic [W-1:0] cnt;
    assign expired = cnt == W'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch (I) and data (D) requesters.
// Define MEM_PORT_ARBITER_STATS_EN to build the grant/conflict statistics counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              err,
    output logic [31:0]       stat_i_grants,
    output logic [31:0]       stat_d_grants,
    output logic [31:0]       stat_conflicts
);
    arb_state_t state, state_nxt;
    owner_t owner;
    logic expired, grant, done;
    logic [DATA_W-1:0] resp_data;

    assign grant = state == IDLE && (d_req || i_req);
    assign done = state == WAIT && (mem_ready || expired);
    // an acknowledge wins over a simultaneous expiry; writes and aborts return zero
    assign resp_data = (mem_ready && !mem_we) ? mem_rdata : '0;

    mem_port_arbiter_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk),
        .reset(reset),
        .clear(state != WAIT),
        .enable(state == WAIT),
        .expired(expired)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  state_nxt = grant ? ISSUE : IDLE;
            ISSUE: state_nxt = WAIT;
            WAIT:  state_nxt = done ? RESP : WAIT;
            RESP:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_I;
            busy      <= 1'b0;
            err       <= 1'b0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= state_nxt != IDLE;
            mem_valid <= grant;
            if (grant) begin
                owner     <= d_req ? OWN_D : OWN_I;
                mem_we    <= d_req && d_we;
                mem_addr  <= d_req ? d_addr : i_addr;
                mem_wdata <= d_req ? d_wdata : '0;
            end
            i_ready <= done && owner == OWN_I;
            d_ready <= done && owner == OWN_D;
            if (done && owner == OWN_I)
                i_rdata <= resp_data;
            if (done && owner == OWN_D)
                d_rdata <= resp_data;
            err <= err || (done && !mem_ready);
        end
    end

`ifdef MEM_PORT_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_i_grants  <= '0;
            stat_d_grants  <= '0;
            stat_conflicts <= '0;
        end else begin
            if (grant && !d_req)
                stat_i_grants <= stat_i_grants + 32'd1;
            if (grant && d_req)
                stat_d_grants <= stat_d_grants + 32'd1;
            if (state == IDLE && i_req && d_req)
                stat_conflicts <= stat_conflicts + 32'd1;
        end
    end
`else
    assign stat_i_grants  = '0;
    assign stat_d_grants  = '0;
    assign stat_conflicts = '0;
`endif
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch requester (IF) and data requester (MEM stage).
- Replaces the separate instruction and data memories once the unified memory is introduced.
- Sequences each access as grant -> issue -> wait -> respond, and returns per-requester ready pulses; the CPU derives its stalls from these.
- Includes a watchdog so a lost memory acknowledge cannot hang the pipeline.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles spent waiting for mem_ready before abort (must be >= 2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request, held until i_ready
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word, valid when i_ready=1
- i_ready  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid when d_ready=1
- d_ready  out  1  one-cycle data completion pulse
- mem_valid  out  1  one-cycle command pulse to memory
- mem_we  out  1  command is a write
- mem_addr  out  ADDR_W  command address
- mem_wdata  out  DATA_W  command write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion pulse
- busy  out  1  FSM not in IDLE
- err  out  1  sticky timeout flag
- stat_i_grants  out  32  fetch grants (optional feature)
- stat_d_grants  out  32  data grants (optional feature)
- stat_conflicts  out  32  IDLE cycles with both requests high (optional feature)

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. All outputs, including mem_*, are registered.
- Reset, synchronous: state=IDLE; all outputs 0; counters 0; err=0. An in-flight access is discarded, and the memory shares the same reset.
- IDLE:
  - If d_req: grant D. Data has fixed priority because it belongs to the older instruction.
  - Else if i_req: grant I.
  - On grant, latch requester, address, we (we=0 for I) and wdata; go to ISSUE.
- ISSUE: mem_valid=1 for exactly this one cycle with the latched command; go to WAIT. mem_ready is ignored in ISSUE.
- WAIT:
  - Watchdog counts from 0.
  - On mem_ready, capture mem_rdata (0 if write) and go to RESP.
  - If the count reaches TIMEOUT-1 without mem_ready: set err, force rdata=0, go to RESP.
- RESP:
  - The owning requester's ready=1 with rdata for one cycle; the other ready stays 0.
  - Return to IDLE. No grant is made in RESP.
- Minimum latency: request seen in IDLE at cycle t -> mem_valid at t+1 -> mem_ready at t+2 or later -> ready at t+3.
- Outside RESP, rdata holds its last value.
- Request dropped mid-access (e.g. IF flush): the access still completes and ready still pulses. The requester ignores the pulse; the arbiter never cancels.
- Changes to addr/wdata after grant have no effect on the access.
- Both requests in the same IDLE cycle: D is served first; I waits and is granted on the next IDLE cycle.
- A requester must deassert req in the cycle after its ready pulse, otherwise it is regranted.
- err stays set until reset; it does not block further operation.

Optional Feature:
- Macro MEM_PORT_ARBITER_STATS_EN.
- Defined: stat_i_grants and stat_d_grants increment on each grant; stat_conflicts increments on each IDLE cycle with i_req&&d_req. Counters are 32-bit, wrap at 2^32-1 -> 0, and clear on reset.
- Undefined: the stat ports exist but are driven constant 0, and no counter registers are synthesized.

Decomposition:
- Package mem_port_arbiter_pkg holds:
  - the arb_state_t enum (IDLE, ISSUE, WAIT, RESP);
  - the owner_t enum (OWN_I, OWN_D);
  - the default TIMEOUT constant.
- One sub-module, mem_port_arbiter_timer: a watchdog counter with inputs clear and enable, output expired at TIMEOUT-1, width $clog2(TIMEOUT).

Test Plan:
- Lone fetch: i_req, i_addr=0x40; memory acks 2 cycles after mem_valid with 0xDEADBEEF -> mem_valid=1, mem_we=0, mem_addr=0x40 at t+1; i_ready=1, i_rdata=0xDEADBEEF at t+4; d_ready stays 0.
- Conflict: i_req (addr 0x8) and d_req load (addr 0x100) in the same cycle -> first mem_addr=0x100, d_ready pulses first; then mem_addr=0x8, i_ready pulses; stat_conflicts=1 when stats are enabled.
- Store: d_req, d_we=1, d_addr=0x20, d_wdata=0x12345678 -> mem_we=1, mem_wdata=0x12345678; d_ready with d_rdata=0.
- Timeout: TIMEOUT=8, mem_ready never asserted -> after 8 WAIT cycles, d_ready=1, d_rdata=0, err=1; err stays 1 after a later successful access.
- Flush/reset: drop i_req in WAIT -> i_ready still pulses once. Assert reset in WAIT -> next cycle busy=0, mem_valid=0, err=0, no ready pulse follows.
